// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator that maps pipeline loads/stores onto a
// word-wide data-memory port; sub-word stores are done as read-modify-write.
module load_store_unit_checker (
  input logic       Clk,
  input logic       Reset,
  input logic       Done,
  input logic       MemRead,
  input logic       MemWrite,
  input logic [1:0] mem_addr_lsb
);
  a_rd_wr_exclusive: assert property (@(posedge Clk) disable iff (Reset) !(MemRead && MemWrite));
  a_done_pulse:      assert property (@(posedge Clk) disable iff (Reset) Done |=> !Done);
  a_word_address:    assert property (@(posedge Clk) disable iff (Reset) mem_addr_lsb == 2'b00);
endmodule

module load_store_unit #(
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ReqValid,
  input  logic [2:0]        ReqOp,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [31:0]       ReqWData,
  output logic              Stall,
  output logic              Done,
  output logic [31:0]       LoadData,
  output logic              AddrErr,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [31:0]       MemWriteData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [31:0]       MemReadData
);
  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  localparam logic [1:0] RD_LAST = 2'(READ_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_MERGE = 3'd2,
    S_WR    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic req_aligned(input logic [2:0] op, input logic [1:0] lsb);
    logic ok;
    case (op)
      OP_LW, OP_SW:         ok = (lsb == 2'b00);
      OP_LH, OP_LHU, OP_SH: ok = (lsb[0] == 1'b0);
      default:              ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] lsb);
    logic [7:0] b;
    case (lsb)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [15:0] pick_half(input logic [31:0] word, input logic upper);
    logic [15:0] h;
    if (upper) begin
      h = word[31:16];
    end else begin
      h = word[15:0];
    end
    return h;
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [2:0] op,
                                              input logic [1:0] lsb);
    logic [31:0] r;
    logic [7:0]  b;
    logic [15:0] h;
    b = pick_byte(word, lsb);
    h = pick_half(word, lsb[1]);
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'h000000, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [15:0] wdata,
                                              input logic [2:0] op, input logic [1:0] lsb);
    logic [31:0] r;
    r = word;
    if (op == OP_SB) begin
      case (lsb)
        2'd0:    r[7:0]   = wdata[7:0];
        2'd1:    r[15:8]  = wdata[7:0];
        2'd2:    r[23:16] = wdata[7:0];
        default: r[31:24] = wdata[7:0];
      endcase
    end else if (op == OP_SH) begin
      if (lsb[1]) begin
        r[31:16] = wdata;
      end else begin
        r[15:0] = wdata;
      end
    end else begin
      r = word;
    end
    return r;
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic [2:0]         op_r;
  logic [1:0]         lsb_r;
  logic [15:0]        wdata_r;
  logic [31:0]        rdata_r;
  logic [1:0]         cnt_r;
  logic               aligned_s;
  logic               accept_s;
  logic               rd_last_s;
  logic               op_is_load_s;

  logic               mem_read_r,   mem_read_nxt_s;
  logic               mem_write_r,  mem_write_nxt_s;
  logic               done_r,       done_nxt_s;
  logic               addr_err_r,   addr_err_nxt_s;
  logic [ADDR_W-1:0]  mem_addr_r,   mem_addr_nxt_s;
  logic [31:0]        mem_wdata_r,  mem_wdata_nxt_s;
  logic [31:0]        load_data_r,  load_data_nxt_s;

  assign aligned_s    = req_aligned(ReqOp, ReqAddr[1:0]);
  assign accept_s     = (state_r == S_IDLE) && ReqValid && aligned_s;
  assign rd_last_s    = (state_r == S_RD) && (cnt_r == RD_LAST);
  assign op_is_load_s = (op_r <= OP_LBU);

  // Stall is forced low while Reset is held so an aborted access never freezes the pipeline.
  assign Stall = !Reset && (((state_r != S_IDLE) && (state_r != S_DONE)) || accept_s);

  assign MemRead      = mem_read_r;
  assign MemWrite     = mem_write_r;
  assign Done         = done_r;
  assign AddrErr      = addr_err_r;
  assign MemAddress   = mem_addr_r;
  assign MemWriteData = mem_wdata_r;
  assign LoadData     = load_data_r;

  // state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nxt_s = (ReqOp == OP_SW) ? S_WR : S_RD;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RD: begin
        if (rd_last_s) begin
          state_nxt_s = op_is_load_s ? S_DONE : S_MERGE;
        end else begin
          state_nxt_s = S_RD;
        end
      end
      S_MERGE: state_nxt_s = S_WR;
      S_WR:    state_nxt_s = S_DONE;
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // next values of the registered outputs, derived from the state being entered
  always_comb begin
    mem_read_nxt_s  = (state_nxt_s == S_RD);
    mem_write_nxt_s = (state_nxt_s == S_WR);
    done_nxt_s      = (state_nxt_s == S_DONE);
    addr_err_nxt_s  = (state_r == S_IDLE) && ReqValid && !aligned_s;
    mem_addr_nxt_s  = mem_addr_r;
    mem_wdata_nxt_s = mem_wdata_r;
    load_data_nxt_s = load_data_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          mem_addr_nxt_s = {ReqAddr[ADDR_W-1:2], 2'b00};
          if (ReqOp == OP_SW) begin
            mem_wdata_nxt_s = ReqWData;
          end else begin
            mem_wdata_nxt_s = mem_wdata_r;
          end
        end else begin
          mem_addr_nxt_s = mem_addr_r;
        end
      end
      S_RD: begin
        if (rd_last_s && op_is_load_s) begin
          load_data_nxt_s = extend_load(MemReadData, op_r, lsb_r);
        end else begin
          load_data_nxt_s = load_data_r;
        end
      end
      S_MERGE: mem_wdata_nxt_s = merge_store(rdata_r, wdata_r, op_r, lsb_r);
      default: load_data_nxt_s = load_data_r;
    endcase
  end

  // registered memory-side and pipeline-side outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      done_r      <= 1'b0;
      addr_err_r  <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= 32'h0000_0000;
      load_data_r <= 32'h0000_0000;
    end else begin
      mem_read_r  <= mem_read_nxt_s;
      mem_write_r <= mem_write_nxt_s;
      done_r      <= done_nxt_s;
      addr_err_r  <= addr_err_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      load_data_r <= load_data_nxt_s;
    end
  end

  // latched request, captured read word and read-latency counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      op_r    <= 3'b000;
      lsb_r   <= 2'b00;
      wdata_r <= 16'h0000;
      rdata_r <= 32'h0000_0000;
      cnt_r   <= 2'b00;
    end else begin
      if (accept_s) begin
        op_r    <= ReqOp;
        lsb_r   <= ReqAddr[1:0];
        wdata_r <= ReqWData[15:0];
      end
      if (rd_last_s) begin
        rdata_r <= MemReadData;
      end
      if (state_r == S_RD) begin
        cnt_r <= cnt_r + 2'd1;
      end else begin
        cnt_r <= 2'b00;
      end
    end
  end

  load_store_unit_checker u_checker (
    .Clk          (Clk),
    .Reset        (Reset),
    .Done         (done_r),
    .MemRead      (mem_read_r),
    .MemWrite     (mem_write_r),
    .mem_addr_lsb (mem_addr_r[1:0])
  );
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table-driven ops on a READ_LAT=1
// instance with a word memory model, plus a READ_LAT=3 back-to-back load sequence.
module tb_load_store_unit;
  localparam int RL_A = 1;
  localparam int RL_B = 3;
  localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011, LBU = 3'b100;
  localparam logic [2:0] SW = 3'b101, SH = 3'b110, SB = 3'b111;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] load;
    logic [31:0] wr_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_req_valid, a_stall, a_done, a_addr_err, a_mem_write, a_mem_read;
  logic [2:0]  a_req_op;
  logic [31:0] a_req_addr, a_req_wdata, a_load_data, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        b_req_valid, b_stall, b_done, b_addr_err, b_mem_write, b_mem_read;
  logic [2:0]  b_req_op;
  logic [31:0] b_req_addr, b_req_wdata, b_load_data, b_mem_addr, b_mem_wdata, b_mem_rdata;

  load_store_unit #(.READ_LAT(RL_A), .ADDR_W(32)) dut_a (
    .Clk(clk), .Reset(rst), .ReqValid(a_req_valid), .ReqOp(a_req_op), .ReqAddr(a_req_addr),
    .ReqWData(a_req_wdata), .Stall(a_stall), .Done(a_done), .LoadData(a_load_data),
    .AddrErr(a_addr_err), .MemAddress(a_mem_addr), .MemWriteData(a_mem_wdata),
    .MemWrite(a_mem_write), .MemRead(a_mem_read), .MemReadData(a_mem_rdata)
  );

  load_store_unit #(.READ_LAT(RL_B), .ADDR_W(32)) dut_b (
    .Clk(clk), .Reset(rst), .ReqValid(b_req_valid), .ReqOp(b_req_op), .ReqAddr(b_req_addr),
    .ReqWData(b_req_wdata), .Stall(b_stall), .Done(b_done), .LoadData(b_load_data),
    .AddrErr(b_addr_err), .MemAddress(b_mem_addr), .MemWriteData(b_mem_wdata),
    .MemWrite(b_mem_write), .MemRead(b_mem_read), .MemReadData(b_mem_rdata)
  );

  // Memory models: read data is only valid on the READ_LAT-th cycle of MemRead.
  logic [31:0] mem_a [0:63];
  int a_lat_cnt = 0, b_lat_cnt = 0;
  int a_rd_cycles = 0, a_wr_count = 0, b_rd_cycles = 0, b_wr_count = 0, both_high = 0;

  always @(posedge clk) begin
    if (a_mem_write) mem_a[a_mem_addr[7:2]] <= a_mem_wdata;
    a_lat_cnt <= a_mem_read ? a_lat_cnt + 1 : 0;
    b_lat_cnt <= b_mem_read ? b_lat_cnt + 1 : 0;
    if (a_mem_read) a_rd_cycles <= a_rd_cycles + 1;
    if (a_mem_write) a_wr_count <= a_wr_count + 1;
    if (b_mem_read) b_rd_cycles <= b_rd_cycles + 1;
    if (b_mem_write) b_wr_count <= b_wr_count + 1;
    if ((a_mem_read && a_mem_write) || (b_mem_read && b_mem_write)) both_high <= both_high + 1;
  end

  assign a_mem_rdata = (a_mem_read && a_lat_cnt == RL_A - 1) ? mem_a[a_mem_addr[7:2]] : 32'hBAD0BAD0;
  assign b_mem_rdata = (b_mem_read && b_lat_cnt == RL_B - 1) ? (32'hA5A50000 | b_mem_addr) : 32'hBAD0BAD0;

  int checks = 0;
  int failures = 0;
  vec_t sb_q[$];
  vec_t vecs[$];
  logic [31:0] last_load = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input vec_t v, input int rl);
    if (v.err) return 1;
    case (v.op)
      SW:      return 2;
      SH, SB:  return rl + 3;
      default: return rl + 1;
    endcase
  endfunction

  function automatic int exp_rd(input vec_t v, input int rl);
    if (v.err || v.op == SW) return 0;
    return rl;
  endfunction

  task automatic apply_a(input vec_t v);
    vec_t e;
    int lat, rd0, wr0;
    bit seen;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_op = v.op; a_req_addr = v.addr; a_req_wdata = v.wdata;
    sb_q.push_back(v);
    rd0 = a_rd_cycles; wr0 = a_wr_count;
    #1;
    check({v.name, "/stall_at_req"}, 32'(a_stall), 32'(!v.err));
    seen = 1'b0; lat = 0;
    for (int c = 1; c <= 12 && !seen; c++) begin
      @(negedge clk);
      if (a_mem_write) begin
        check({v.name, "/wr_addr"}, a_mem_addr, {v.addr[31:2], 2'b00});
        check({v.name, "/wr_data"}, a_mem_wdata, v.wr_data);
      end
      if (a_done || a_addr_err) begin
        seen = 1'b1; lat = c;
      end
    end
    a_req_valid = 1'b0;
    e = sb_q.pop_front();
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s/timeout: no Done or AddrErr within 12 cycles", e.name);
    end else begin
      check({e.name, "/latency"}, 32'(lat), 32'(exp_lat(e, RL_A)));
      check({e.name, "/done_err"}, {30'd0, a_done, a_addr_err}, {30'd0, !e.err, e.err});
      if (!e.err && e.op <= LBU) begin
        check({e.name, "/load_data"}, a_load_data, e.load);
        last_load = e.load;
      end else begin
        check({e.name, "/load_hold"}, a_load_data, last_load);
      end
    end
    @(negedge clk);
    check({e.name, "/pulse_end"}, {30'd0, a_done, a_addr_err}, 32'd0);
    check({e.name, "/rd_cycles"}, 32'(a_rd_cycles - rd0), 32'(exp_rd(e, RL_A)));
    check({e.name, "/wr_count"}, 32'(a_wr_count - wr0), 32'(!e.err && e.op >= SW));
  endtask

  task automatic wait_done_b(output int lat);
    lat = 0;
    for (int c = 1; c <= 16 && lat == 0; c++) begin
      @(negedge clk);
      if (b_done) lat = c;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    int lat, rd0, wr0;
    rst = 1'b1;
    a_req_valid = 1'b0; a_req_op = 3'b000; a_req_addr = 32'h0; a_req_wdata = 32'h0;
    b_req_valid = 1'b0; b_req_op = 3'b000; b_req_addr = 32'h0; b_req_wdata = 32'h0;

    vecs.push_back('{"sw_14",     SW,  32'h14, 32'hDEADBEEF, 1'b0, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{"sw_20",     SW,  32'h20, 32'h12345678, 1'b0, 32'h0,        32'h12345678});
    vecs.push_back('{"lb_23",     LB,  32'h23, 32'h0,        1'b0, 32'h00000012, 32'h0});
    vecs.push_back('{"lh_20",     LH,  32'h20, 32'h0,        1'b0, 32'h00005678, 32'h0});
    vecs.push_back('{"lbu_21",    LBU, 32'h21, 32'h0,        1'b0, 32'h00000056, 32'h0});
    vecs.push_back('{"lw_14",     LW,  32'h14, 32'h0,        1'b0, 32'hDEADBEEF, 32'h0});
    vecs.push_back('{"lb_14",     LB,  32'h14, 32'h0,        1'b0, 32'hFFFFFFEF, 32'h0});
    vecs.push_back('{"lbu_15",    LBU, 32'h15, 32'h0,        1'b0, 32'h000000BE, 32'h0});
    vecs.push_back('{"lh_16",     LH,  32'h16, 32'h0,        1'b0, 32'hFFFFDEAD, 32'h0});
    vecs.push_back('{"lhu_16",    LHU, 32'h16, 32'h0,        1'b0, 32'h0000DEAD, 32'h0});
    vecs.push_back('{"sw_24",     SW,  32'h24, 32'h0000F0F0, 1'b0, 32'h0,        32'h0000F0F0});
    vecs.push_back('{"lh_24",     LH,  32'h24, 32'h0,        1'b0, 32'hFFFFF0F0, 32'h0});
    vecs.push_back('{"lhu_24",    LHU, 32'h24, 32'h0,        1'b0, 32'h0000F0F0, 32'h0});
    vecs.push_back('{"sw_30",     SW,  32'h30, 32'h11223344, 1'b0, 32'h0,        32'h11223344});
    vecs.push_back('{"sb_31",     SB,  32'h31, 32'hFFFFFFAB, 1'b0, 32'h0,        32'h1122AB44});
    vecs.push_back('{"sw_30b",    SW,  32'h30, 32'h11223344, 1'b0, 32'h0,        32'h11223344});
    vecs.push_back('{"sh_32",     SH,  32'h32, 32'h5555BEEF, 1'b0, 32'h0,        32'hBEEF3344});
    vecs.push_back('{"sb_33",     SB,  32'h33, 32'h00000055, 1'b0, 32'h0,        32'h55EF3344});
    vecs.push_back('{"sb_30",     SB,  32'h30, 32'h0000009A, 1'b0, 32'h0,        32'h55EF339A});
    vecs.push_back('{"sh_20",     SH,  32'h20, 32'h0000CAFE, 1'b0, 32'h0,        32'h1234CAFE});
    vecs.push_back('{"lw_30",     LW,  32'h30, 32'h0,        1'b0, 32'h55EF339A, 32'h0});
    vecs.push_back('{"lw_20",     LW,  32'h20, 32'h0,        1'b0, 32'h1234CAFE, 32'h0});
    vecs.push_back('{"lb_31",     LB,  32'h31, 32'h0,        1'b0, 32'h00000033, 32'h0});
    vecs.push_back('{"lb_32",     LB,  32'h32, 32'h0,        1'b0, 32'hFFFFFFEF, 32'h0});
    vecs.push_back('{"mis_lw_22", LW,  32'h22, 32'h0,        1'b1, 32'h0,        32'h0});
    vecs.push_back('{"mis_sh_33", SH,  32'h33, 32'h00001111, 1'b1, 32'h0,        32'h0});
    vecs.push_back('{"mis_lhu_21",LHU, 32'h21, 32'h0,        1'b1, 32'h0,        32'h0});
    vecs.push_back('{"mis_sw_12", SW,  32'h12, 32'h22222222, 1'b1, 32'h0,        32'h0});
    vecs.push_back('{"lw_30b",    LW,  32'h30, 32'h0,        1'b0, 32'h55EF339A, 32'h0});
    vecs.push_back('{"lw_24",     LW,  32'h24, 32'h0,        1'b0, 32'h0000F0F0, 32'h0});

    // reset state
    repeat (2) @(negedge clk);
    check("reset/ctrl", {27'd0, a_stall, a_done, a_addr_err, a_mem_write, a_mem_read}, 32'd0);
    check("reset/load_data", a_load_data, 32'h0);
    check("reset/mem_addr", a_mem_addr, 32'h0);
    check("reset/mem_wdata", a_mem_wdata, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) apply_a(vecs[i]);

    // reset while a sub-word store sits in RD
    @(negedge clk);
    a_req_valid = 1'b1; a_req_op = SB; a_req_addr = 32'h31; a_req_wdata = 32'h77;
    @(posedge clk); #1;
    check("rst_mid/in_rd", {30'd0, a_mem_read, a_stall}, 32'd3);
    wr0 = a_wr_count;
    rst = 1'b1; #1;
    check("rst_mid/ctrl", {27'd0, a_stall, a_done, a_addr_err, a_mem_write, a_mem_read}, 32'd0);
    check("rst_mid/load_data", a_load_data, 32'h0);
    check("rst_mid/mem_addr", a_mem_addr, 32'h0);
    check("rst_mid/mem_wdata", a_mem_wdata, 32'h0);
    a_req_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_mid/no_write", 32'(a_wr_count - wr0), 32'd0);
    check("rst_mid/idle", {29'd0, a_stall, a_mem_read, a_done}, 32'd0);

    // READ_LAT=3: back-to-back word loads, second presented in the DONE cycle
    @(negedge clk);
    b_req_valid = 1'b1; b_req_op = LW; b_req_addr = 32'h0;
    sb_q.push_back('{"b_lw_0", LW, 32'h0, 32'h0, 1'b0, 32'hA5A50000, 32'h0});
    rd0 = b_rd_cycles;
    wait_done_b(lat);
    e = sb_q.pop_front();
    check({e.name, "/latency"}, 32'(lat), 32'(RL_B + 1));
    check({e.name, "/load_data"}, b_load_data, e.load);
    check({e.name, "/rd_cycles"}, 32'(b_rd_cycles - rd0), 32'(RL_B));
    b_req_addr = 32'h4;
    sb_q.push_back('{"b_lw_4", LW, 32'h4, 32'h0, 1'b0, 32'hA5A50004, 32'h0});
    #1;
    check("b_done_cycle/stall", 32'(b_stall), 32'd0);
    rd0 = b_rd_cycles;
    @(negedge clk);
    check("b_idle_gap", {29'd0, b_done, b_mem_read, b_stall}, 32'd1);
    wait_done_b(lat);
    b_req_valid = 1'b0;
    e = sb_q.pop_front();
    check({e.name, "/latency"}, 32'(lat), 32'(RL_B + 1));
    check({e.name, "/load_data"}, b_load_data, e.load);
    check({e.name, "/rd_cycles"}, 32'(b_rd_cycles - rd0), 32'(RL_B));
    @(negedge clk);
    check("b_done_pulse", 32'(b_done), 32'd0);
    check("b_no_write", 32'(b_wr_count), 32'd0);
    check("rd_wr_exclusive", 32'(both_high), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
MEM-stage initiator that turns pipeline load/store requests into word-wide accesses on the data-memory port.
- Word stores go out directly.
- Byte and halfword stores are done as a read-modify-write of the containing word.
- Loads return byte, halfword or word data, sign- or zero-extended.
- The unit stalls the pipeline while an access is in flight and flags misaligned accesses.

Parameters:
READ_LAT, 1, cycles from MemRead asserted to MemReadData valid (1..3)
ADDR_W, 32, address width

Ports:
Clk  input  1  clock
Reset  input  1  asynchronous, active-high reset
ReqValid  input  1  pipeline presents a memory op; held stable while Stall=1
ReqOp  input  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb
ReqAddr  input  ADDR_W  byte address
ReqWData  input  32  store data, right-justified
Stall  output  1  hold pipeline
Done  output  1  one-cycle pulse, op complete
LoadData  output  32  extended load result, valid when Done=1 for a load
AddrErr  output  1  one-cycle pulse, misaligned request rejected
MemAddress  output  ADDR_W  word-aligned address to memory ([1:0]=00)
MemWriteData  output  32  full word to write
MemWrite  output  1  memory write strobe
MemRead  output  1  memory read strobe
MemReadData  input  32  word returned by memory

Behaviour:
Reset:
- Reset=1 asynchronously forces state IDLE.
- Stall, Done, AddrErr, MemWrite and MemRead go to 0.
- LoadData, MemAddress and MemWriteData go to 0x00000000.
- A reset during any state aborts the access. No write is issued after reset deasserts.

Registers and decode:
- All memory-side outputs are registered.
- Stall is combinational: Stall = (state not in {IDLE, DONE}) or (state==IDLE and ReqValid and aligned).
- Alignment: lw/sw need ReqAddr[1:0]=00; lh/lhu/sh need ReqAddr[0]=0; byte ops are always aligned.
- The request is latched on the posedge when state==IDLE and ReqValid=1.

States:
- IDLE:
  - Misaligned request: AddrErr=1 for the next cycle, no memory access, state stays IDLE. The pipeline must drop ReqValid.
  - sw: go to WR.
  - Other aligned request: go to RD.
- RD:
  - MemRead=1 and MemAddress={addr[ADDR_W-1:2],00} for READ_LAT cycles.
  - MemReadData is captured on the final RD cycle's posedge.
  - Load: go to DONE.
  - sh/sb: go to MERGE.
- MERGE:
  - Registers the captured word with the store lane replaced.
  - Byte lane k = addr[1:0] gets ReqWData[7:0] in bits [8k+7:8k].
  - Halfword: addr[1]=0 writes [15:0], addr[1]=1 writes [31:16], from ReqWData[15:0].
  - Other bits are unchanged. Go to WR.
- WR:
  - MemWrite=1 for exactly one cycle with MemAddress and MemWriteData. Memory commits on that posedge.
  - sw uses ReqWData unchanged. Go to DONE.
- DONE:
  - Done=1 and Stall=0.
  - For loads, LoadData holds the extended value: lb/lh sign-extend from bit 7/15, lbu/lhu zero-extend, lw passes through. Lane is selected as in MERGE.
  - Always go to IDLE. A new request is not accepted in DONE.

Latency (edges after acceptance until Done high):
- sw: 2
- load: READ_LAT+1
- sh/sb: READ_LAT+3

Hold rules:
- MemRead and MemWrite are never high together.
- LoadData holds its value until the next load's DONE.
- Request inputs changing while Stall=1 is a pipeline protocol violation. The unit uses its latched copy.

Test Plan:
- Reset mid-access: Reset pulse while in RD -> all outputs 0 immediately, state IDLE, no MemWrite afterwards.
- sw to 0x14 with 0xDEADBEEF -> MemWrite=1 for one cycle, MemAddress=0x14, MemWriteData=0xDEADBEEF, Done 2 edges after acceptance.
- Word 0x12345678 at 0x20; lb addr 0x23 -> LoadData=0x00000012; lh addr 0x20 -> 0x00005678; memory 0x0000F0F0, lh -> 0xFFFFF0F0, lhu -> 0x0000F0F0.
- Word 0x11223344 at 0x30; sb 0xAB to 0x31 -> one read then one write of 0x1122AB44; sh 0xBEEF to 0x32 -> 0xBEEF3344; Done at READ_LAT+3.
- Misaligned: lw at 0x22 and sh at 0x33 -> AddrErr one-cycle pulse, MemRead/MemWrite stay 0, Stall stays 0.
- READ_LAT=3 back-to-back lw 0x0 then lw 0x4 -> MemRead high 3 cycles each, Done pulses 4 edges after each acceptance, IDLE cycle between them, correct words returned.
